// File: rtl/uc_fsm.sv
// rtl/uc_fsm.sv - microc control unit: opcode decode plus RUN/HALT/TRAP sequencing
module uc_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        z,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  Op,
    output logic        halted,
    output logic        trap,
    output logic [15:0] ret_cnt
);

    localparam logic [5:0] OP_LI   = 6'b010000;
    localparam logic [5:0] OP_J    = 6'b010001;
    localparam logic [5:0] OP_JZ   = 6'b010010;
    localparam logic [5:0] OP_JNZ  = 6'b010011;
    localparam logic [5:0] OP_HALT = 6'b011111;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t state;
    logic   is_alu;
    logic   legal;
    logic   decode_en;

    assign is_alu    = (Opcode[5:4] == 2'b00);
    assign legal     = is_alu || (Opcode == OP_LI) || (Opcode == OP_J) ||
                       (Opcode == OP_JZ) || (Opcode == OP_JNZ) || (Opcode == OP_HALT);
    // During reset the datapath is frozen anyway, so decode behaves as in RUN.
    assign decode_en = (state == RUN) || reset;

    always_comb begin
        s_inc = 1'b0;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        Op    = 3'b000;
        if (decode_en) begin
            if (is_alu) begin
                Op    = Opcode[2:0];
                s_inc = 1'b1;
                we3   = 1'b1;
                wez   = 1'b1;
            end else begin
                case (Opcode)
                    OP_LI: begin
                        s_inc = 1'b1;
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end
                    OP_JZ:   s_inc = ~z;
                    OP_JNZ:  s_inc = z;
                    default: s_inc = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            halted  <= 1'b0;
            trap    <= 1'b0;
            ret_cnt <= 16'h0000;
        end else begin
            case (state)
                RUN: begin
                    if (legal && (ret_cnt != 16'hFFFF))
                        ret_cnt <= ret_cnt + 16'd1;
                    if (Opcode == OP_HALT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!legal) begin
                        state <= TRAP;
                        trap  <= 1'b1;
                    end
                end
                HALT:    state <= HALT;
                TRAP:    state <= TRAP;
                default: begin
                    state  <= TRAP;
                    trap   <= 1'b1;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uc_fsm.sv
// tb/tb_uc_fsm.sv - self-checking bench for uc_fsm against a behavioural model
module tb_uc_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic        z;
    logic        s_inc, s_inm, we3, wez;
    logic [2:0]  Op;
    logic        halted, trap;
    logic [15:0] ret_cnt;

    int checks   = 0;
    int failures = 0;

    // model: 0 = running, 1 = halted, 2 = trapped
    int  m_mode  = 0;
    int  m_count = 0;
    bit  m_valid = 1'b0;

    uc_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (Opcode),
        .z       (z),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we3     (we3),
        .wez     (wez),
        .Op      (Op),
        .halted  (halted),
        .trap    (trap),
        .ret_cnt (ret_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] op);
        return (op[5:4] == 2'b00) || (op == 6'd16) || (op == 6'd17) ||
               (op == 6'd18) || (op == 6'd19) || (op == 6'd31);
    endfunction

    // returns {s_inc, s_inm, we3, wez, Op}
    function automatic logic [6:0] exp_ctl(input int mode, input logic rst,
                                           input logic [5:0] op, input logic zz);
        if (mode != 0 && !rst) return 7'b0;
        if (op[5:4] == 2'b00)  return {4'b1011, op[2:0]};
        case (op)
            6'd16:   return 7'b1110_000;
            6'd18:   return {~zz, 6'b0};
            6'd19:   return {zz, 6'b0};
            default: return 7'b0;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_mode  = 0;
            m_count = 0;
            m_valid = 1'b1;
        end else if (m_mode == 0) begin
            if (is_legal(Opcode) && m_count < 65535) m_count = m_count + 1;
            if (Opcode == 6'd31)         m_mode = 1;
            else if (!is_legal(Opcode))  m_mode = 2;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ctl", {s_inc, s_inm, we3, wez, Op}, exp_ctl(m_mode, reset, Opcode, z));
            check("halted", halted, m_mode == 1);
            check("trap", trap, m_mode == 2);
            check("ret_cnt", ret_cnt, m_count);
        end
    end

    task automatic setin(input logic rst, input logic [5:0] op, input logic zz);
        reset  = rst;
        Opcode = op;
        z      = zz;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        setin(1'b1, 6'd0, 1'b0);
        tick();
        check("reset_halted", halted, 0);
        check("reset_trap", trap, 0);
        check("reset_cnt", ret_cnt, 0);

        setin(1'b0, 6'b010000, 1'b0);
        check("li_ctl", {s_inc, s_inm, we3, wez}, 4'b1110);
        tick();
        check("li_cnt", ret_cnt, 1);

        setin(1'b0, 6'b000011, 1'b0);
        check("alu_ctl", {s_inc, s_inm, we3, wez, Op}, 7'b1011_011);
        tick();
        check("alu_cnt", ret_cnt, 2);

        setin(1'b0, 6'b010010, 1'b1);
        check("jz_z1", s_inc, 0);
        tick();
        setin(1'b0, 6'b010010, 1'b0);
        check("jz_z0", s_inc, 1);
        tick();
        setin(1'b0, 6'b010011, 1'b1);
        check("jnz_z1", s_inc, 1);
        tick();
        setin(1'b0, 6'b010011, 1'b0);
        check("jnz_z0", {s_inc, we3, wez}, 0);
        tick();
        check("jump_cnt", ret_cnt, 6);

        setin(1'b0, 6'b011111, 1'b0);
        check("halt_ctl", {s_inc, we3, wez}, 0);
        tick();
        check("halt_flag", halted, 1);
        check("halt_cnt", ret_cnt, 7);
        setin(1'b0, 6'b000000, 1'b1);
        check("halt_alu_off", {s_inc, s_inm, we3, wez, Op}, 0);
        tick();
        check("halt_frozen", ret_cnt, 7);

        setin(1'b1, 6'b000000, 1'b0);
        tick();
        check("halt_reset", halted, 0);
        setin(1'b0, 6'b010000, 1'b0);
        tick();
        setin(1'b0, 6'b010101, 1'b0);
        tick();
        check("trap_flag", trap, 1);
        check("trap_cnt", ret_cnt, 1);
        setin(1'b1, 6'b010101, 1'b0);
        check("reset_decode", {s_inc, we3}, 0);
        tick();
        check("trap_cleared", trap, 0);
        check("trap_reset_cnt", ret_cnt, 0);
        setin(1'b0, 6'b000101, 1'b0);
        check("resume_ctl", {s_inc, s_inm, we3, wez, Op}, 7'b1011_101);
        tick();

        setin(1'b1, 6'b011111, 1'b0);
        tick();
        check("halt_under_reset", halted, 0);
        check("halt_under_reset_cnt", ret_cnt, 0);

        for (int i = 0; i < 65537; i++) begin
            setin(1'b0, {2'b00, 4'($urandom_range(0, 15))}, 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end
        check("sat_cnt", ret_cnt, 16'hFFFF);
        setin(1'b0, 6'b000001, 1'b0);
        tick();
        check("sat_hold", ret_cnt, 16'hFFFF);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 45)      op = {2'b00, 4'($urandom_range(0, 15))};
            else if (sel < 80) op = 6'($urandom_range(16, 19));
            else if (sel < 87) op = 6'd31;
            else               op = 6'($urandom_range(0, 63));
            setin(($urandom_range(0, 29) == 0), op, 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
